// File: rtl/md_sched_if.sv
// Issue/result bundle between the E-stage and the multiply/divide scheduler.
// master = pipeline side driving requests, slave = md_sched.
interface md_sched_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler owning the HI/LO registers.
// Optional MD_DIV_ZERO_EARLY_EN: a divide by zero finishes after a single busy cycle.
//
// state | meaning
// IDLE  | accepts mult/div starts and mthi/mtlo writes
// RUN   | operation in flight, cnt counts down to the commit edge
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_sched_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept, commit;
    logic        is_mult_in, is_div_in;
    logic [3:0]  cnt_load;

    assign is_mult_in = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
    assign is_div_in  = (bus.md_op == OP_DIV)  || (bus.md_op == OP_DIVU);

`ifdef MD_DIV_ZERO_EARLY_EN
    assign cnt_load = is_mult_in ? MULT_LOAD :
                      (bus.src_b == 32'd0) ? 4'd0 : DIV_LOAD;
`else
    assign cnt_load = is_mult_in ? MULT_LOAD : DIV_LOAD;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && (is_mult_in || is_div_in)) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Products from latched operands.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = $signed(a_q) * $signed(b_q);
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // One unsigned divider serves both div and divu; signed div works on magnitudes
    // so that 0x80000000 / -1 cannot overflow the datapath.
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uq, ur, quot, rem;
    assign neg_a = (op_q == OP_DIV) && a_q[31];
    assign neg_b = (op_q == OP_DIV) && b_q[31];
    assign mag_a = neg_a ? (32'd0 - a_q) : a_q;
    assign mag_b = neg_b ? (32'd0 - b_q) : b_q;
    assign uq    = (b_q == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign ur    = (b_q == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign quot  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem   = neg_a ? (32'd0 - ur) : ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= commit;

            if (accept) begin
                op_q  <= bus.md_op;
                a_q   <= bus.src_a;
                b_q   <= bus.src_b;
                cnt_q <= cnt_load;
            end else if ((state_q == RUN) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (commit) begin
                case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            lo_q <= quot;
                            hi_q <= rem;
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == IDLE) begin
                if (bus.md_op == OP_MTHI) hi_q <= bus.src_a;
                if (bus.md_op == OP_MTLO) lo_q <= bus.src_a;
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched with an arithmetic reference model of HI/LO.
// Build with +define+MD_DIV_ZERO_EARLY_EN to match the early divide-by-zero variant.
module tb_md_sched;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    md_sched_if bus();

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic void model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                p = 64'(q); m_lo = p[31:0];
                p = 64'(r); m_hi = p[31:0];
            end
            4'd4: if (b != 0) begin
                p = 64'(a) / 64'(b); m_lo = p[31:0];
                p = 64'(a) % 64'(b); m_hi = p[31:0];
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd1 || op == 4'd2) return MULT_N;
`ifdef MD_DIV_ZERO_EARLY_EN
        if (b == 32'd0) return 1;
`endif
        return DIV_N;
    endfunction

    // Drives a start at the current negedge; returns at the negedge where done is seen.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy, output int done_at);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
        nbusy = 0; done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = 4'd0;
            bus.src_a = $urandom; bus.src_b = $urandom;
            if (bus.busy) nbusy++;
            if (bus.done) begin done_at = k; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0; bus.md_op = 4'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        reset = 1'b1;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_directed;
        int nb, da;
        logic [3:0]  op[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [31:0] av[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7};
        logic [31:0] bv[4] = '{32'd3, 32'd2, 32'd2, 32'd2};
        logic [31:0] eh[4] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'd1};
        logic [31:0] el[4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd3};
        for (int i = 0; i < 4; i++) begin
            issue(op[i], av[i], bv[i], nb, da);
            model_apply(op[i], av[i], bv[i]);
            checks++; if (nb != exp_busy(op[i], bv[i])) begin failures++; $display("FAIL dir%0d_busy got=%0d exp=%0d", i, nb, exp_busy(op[i], bv[i])); end
            checks++; if (da != exp_busy(op[i], bv[i]) + 1) begin failures++; $display("FAIL dir%0d_done_cycle got=%0d exp=%0d", i, da, exp_busy(op[i], bv[i]) + 1); end
            checks++; if (bus.hi !== eh[i] || m_hi !== eh[i]) begin failures++; $display("FAIL dir%0d_hi got=%h exp=%h", i, bus.hi, eh[i]); end
            checks++; if (bus.lo !== el[i] || m_lo !== el[i]) begin failures++; $display("FAIL dir%0d_lo got=%h exp=%h", i, bus.lo, el[i]); end
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_width got=%b exp=0", i, bus.done); end
        end
    endtask

    task automatic test_mthi_mtlo;
        bus.md_op = 4'd5; bus.src_a = 32'h12345678; bus.start = 1'b1;
        @(negedge clk);
        bus.md_op = 4'd6; bus.src_a = 32'h9ABCDEF0; bus.start = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mthi got=%h exp=12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL mthi_busy_done got=%b%b exp=00", bus.busy, bus.done); end
        @(negedge clk);
        bus.md_op = 4'd0;
        checks++; if (bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678) begin failures++; $display("FAIL mtlo got=%h/%h exp=12345678/9abcdef0", bus.hi, bus.lo); end
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_div_zero;
        int nb, da;
        bus.md_op = 4'd5; bus.src_a = 32'hAAAA0000; @(negedge clk);
        bus.md_op = 4'd6; bus.src_a = 32'h00005555; @(negedge clk);
        m_hi = 32'hAAAA0000; m_lo = 32'h00005555;
        for (int i = 0; i < 2; i++) begin
            issue(4'd3 + 4'(i), 32'd1234, 32'd0, nb, da);
            model_apply(4'd3 + 4'(i), 32'd1234, 32'd0);
            checks++; if (nb != exp_busy(4'd3, 32'd0)) begin failures++; $display("FAIL divzero%0d_busy got=%0d exp=%0d", i, nb, exp_busy(4'd3, 32'd0)); end
            checks++; if (da != exp_busy(4'd3, 32'd0) + 1) begin failures++; $display("FAIL divzero%0d_done got=%0d exp=%0d", i, da, exp_busy(4'd3, 32'd0) + 1); end
            checks++; if (bus.hi !== 32'hAAAA0000 || bus.lo !== 32'h00005555) begin failures++; $display("FAIL divzero%0d_hilo got=%h/%h exp=aaaa0000/00005555", i, bus.hi, bus.lo); end
        end
    endtask

    task automatic test_ignore_while_busy;
        int nb = 0, da = -1;
        logic [31:0] a = $urandom, b = $urandom;
        bus.start = 1'b1; bus.md_op = 4'd1; bus.src_a = a; bus.src_b = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = 4'd0;
            if (k == 2) begin bus.start = 1'b1; bus.md_op = 4'd3; bus.src_a = $urandom; bus.src_b = 32'd3; end
            if (k == 3) begin bus.md_op = 4'd5; bus.src_a = 32'hDEADBEEF; end
            if (bus.busy) begin
                nb++;
                checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL hold_cycle%0d got=%h/%h exp=%h/%h", k, bus.hi, bus.lo, m_hi, m_lo); end
            end
            if (bus.done) begin da = k; break; end
        end
        model_apply(4'd1, a, b);
        checks++; if (nb != MULT_N || da != MULT_N + 1) begin failures++; $display("FAIL busy_ignore_timing got=%0d/%0d exp=%0d/%0d", nb, da, MULT_N, MULT_N + 1); end
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL busy_ignore_result got=%h/%h exp=%h/%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_ignore_no_queue got=%b exp=0", bus.busy); end
    endtask

    task automatic test_ignored_ops;
        int r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(6, 15);
            bus.start = 1'b1; bus.md_op = (r == 6) ? 4'd0 : 4'(r);
            bus.src_a = $urandom; bus.src_b = $urandom;
            @(negedge clk);
            checks++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL ignored_op%0d busy=%b hi=%h lo=%h exp=0/%h/%h", r, bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
        end
        bus.start = 1'b0; bus.md_op = 4'd0;
    endtask

    task automatic test_back_to_back;
        int nb, da;
        logic [31:0] a = $urandom, b = $urandom, c = $urandom, d = $urandom_range(1, 1000);
        issue(4'd2, a, b, nb, da);
        model_apply(4'd2, a, b);
        checks++; if (da != MULT_N + 1 || bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL b2b_first done=%0d hi=%h lo=%h exp=%0d/%h/%h", da, bus.hi, bus.lo, MULT_N + 1, m_hi, m_lo); end
        issue(4'd3, c, d, nb, da);
        model_apply(4'd3, c, d);
        checks++; if (nb != DIV_N || da != DIV_N + 1) begin failures++; $display("FAIL b2b_second_timing got=%0d/%0d exp=%0d/%0d", nb, da, DIV_N, DIV_N + 1); end
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL b2b_second_result got=%h/%h exp=%h/%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int nb, da, kind;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(1, 6);
            op = 4'(kind);
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (kind >= 5) begin
                bus.md_op = op; bus.src_a = a; bus.start = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.md_op = 4'd0; bus.start = 1'b0;
                model_apply(op, a, b);
                checks++; if (bus.hi !== m_hi || bus.lo !== m_lo || bus.busy !== 1'b0) begin failures++; $display("FAIL rand%0d_move hi=%h lo=%h busy=%b exp=%h/%h/0", i, bus.hi, bus.lo, bus.busy, m_hi, m_lo); end
            end else begin
                issue(op, a, b, nb, da);
                model_apply(op, a, b);
                checks++; if (nb != exp_busy(op, b) || da != exp_busy(op, b) + 1) begin failures++; $display("FAIL rand%0d_timing op=%0d got=%0d/%0d exp=%0d/%0d", i, op, nb, da, exp_busy(op, b), exp_busy(op, b) + 1); end
                checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin failures++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h/%h exp=%h/%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_abort;
        int saw_done = 0;
        bus.md_op = 4'd5; bus.src_a = 32'h11112222; @(negedge clk);
        bus.md_op = 4'd6; bus.src_a = 32'h33334444; @(negedge clk);
        bus.start = 1'b1; bus.md_op = 4'd1; bus.src_a = 32'd7; bus.src_b = 32'd9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = 4'd0;
        end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy got=%b exp=1", bus.busy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL abort_async_busy got=%b%b exp=00", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL abort_async_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
        m_hi = 0; m_lo = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done++;
        end
        checks++; if (saw_done != 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin failures++; $display("FAIL abort_no_result activity=%0d hi=%h lo=%h exp=0/0/0", saw_done, bus.hi, bus.lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_div_zero();
        test_ignore_while_busy();
        test_ignored_ops();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy length in cycles for mult/multu (legal 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy length in cycles for div/divu (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage request; valid only with a start-class md_op.
REQ-006 md_op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7..15 treated as none.
REQ-007 src_a  input  32  rs operand (dividend or multiplicand; mthi/mtlo data).
REQ-008 src_b  input  32  rt operand (divisor or multiplier).
REQ-009 busy  output  1  high while a mult/div is in progress.
REQ-010 done  output  1  one-cycle pulse on the cycle HI/LO take a mult/div result.
REQ-011 hi  output  32  current HI register.
REQ-012 lo  output  32  current LO register.

Function
REQ-013 Two-state FSM: IDLE and RUN; 4-bit down-counter cnt; latched operands op_q, a_q, b_q.
REQ-014 IDLE, start=1, md_op in 1..4 -> latch md_op/src_a/src_b; cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES); go to RUN at that edge.
REQ-015 busy = (state==RUN): first busy cycle is the cycle after start, busy stays high for exactly N cycles.
REQ-016 RUN, cnt!=0 -> cnt decrements by 1 per cycle.
REQ-017 RUN, cnt==0 -> at that edge write HI/LO, assert done for the next cycle, return to IDLE.
REQ-018 mult: {hi,lo} <= signed 64-bit product. multu: unsigned 64-bit product.
REQ-019 div: lo <= signed quotient and hi <= signed remainder, with truncation toward zero and the remainder taking the dividend's sign. divu: unsigned quotient and remainder.
REQ-020 div/divu with b_q==0 leaves hi/lo unchanged; done still pulses.
REQ-021 IDLE, md_op=5 (mthi) -> hi <= src_a next edge; md_op=6 (mtlo) -> lo <= src_a. No busy, no done. The start input is ignored for these ops.
REQ-022 start or mthi/mtlo while busy=1 is ignored. No state, operand or HI/LO change occurs; the hazard unit stalls issue.
REQ-023 start with md_op in 0 or 7..15 is ignored.
REQ-024 hi/lo are register outputs, so mfhi/mflo read them directly. hi/lo hold their value throughout RUN until the commit edge.
REQ-025 Back-to-back: a start in the done cycle (IDLE) is accepted, and busy rises on the next cycle.
REQ-026 Arithmetic uses latched operands only; src_a/src_b changes during RUN have no effect.

Reset
REQ-027 reset low -> immediately (asynchronously) state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, op_q/a_q/b_q=0.
REQ-028 reset during RUN aborts the operation; no result is written after release.
REQ-029 First start is accepted on the first rising edge with reset high.

Configuration
REQ-030 Macro MD_DIV_ZERO_EARLY_EN.
REQ-031 When defined: div/divu with src_b==0 at start runs for exactly 1 busy cycle, then done pulses, with hi/lo unchanged.
REQ-032 When undefined: divide-by-zero runs the full DIV_CYCLES with hi/lo unchanged (REQ-020).

Verification
REQ-033 mult a=0xFFFFFFFE, b=3 -> busy high cycles 1..5, done at cycle 6, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-034 multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-035 div a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1.
REQ-036 mthi 0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0. A start during RUN is ignored, and the result is that of the first op only.
REQ-037 div by 0 with hi=0xAAAA0000, lo=0x5555 -> hi/lo unchanged. Busy lasts 10 cycles without the macro and 1 cycle with MD_DIV_ZERO_EARLY_EN.
REQ-038 reset low at busy cycle 3 of mult -> busy=0 and hi=lo=0 immediately, and no done pulse afterward.
